// File: rtl/sparkle_sequencer_pkg.sv
// Shared constants and state encoding for the sparkle sprite sequencer,
// also consumed by the ROM init tooling and the VGA sprite placement logic.
package sparkle_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int SPARKLE_FRAME_PIXELS = 400;
  localparam int SPARKLE_NUM_FRAMES   = 4;

  // Width of a frame index; never zero so a single-frame build still elaborates.
  function automatic int frame_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sparkle_sequencer_if.sv
// Pixel-pipeline / ROM side of the sparkle sequencer, plus the FSM state for observation.
interface sparkle_sequencer_if #(
  parameter int ADDR_W  = 12,
  parameter int FRAME_W = 2
) ();
  import sparkle_pkg::*;

  // Strobe protocol: there is no ready/backpressure. sparkle is meaningful only
  // in a cycle where sparkle_valid is high and must be consumed that cycle;
  // rom_q must carry the bit for rom_addr exactly ROM_LAT cycles later.
  logic              sparkle_here;
  logic [ADDR_W-1:0] sparkle_pixel;
  logic              trigger;
  logic              loop_mode;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_q;
  logic              sparkle;
  logic              sparkle_valid;
  logic [FRAME_W-1:0] frame_idx;
  logic              busy;
  logic              done;
  state_t            state;

  modport master (
    output sparkle_here, sparkle_pixel, trigger, loop_mode, rom_q,
    input  rom_addr, sparkle, sparkle_valid, frame_idx, busy, done, state
  );

  modport slave (
    input  sparkle_here, sparkle_pixel, trigger, loop_mode, rom_q,
    output rom_addr, sparkle, sparkle_valid, frame_idx, busy, done, state
  );

endinterface

// File: rtl/sparkle_sequencer_valid_pipe.sv
// Delay line for the pixel-valid bit so it lines up with the ROM data return.
module sparkle_valid_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  if (DEPTH < 2) begin : g_bad_depth
    $error("sparkle_valid_pipe: DEPTH must be at least 2");
  end

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
    end else begin
      sr <= {sr[DEPTH-2:0], d};
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/sparkle_sequencer.sv
// Steps the sparkle animation through its frames on a tick period and forms
// sprite ROM addresses, returning the ROM bit with an aligned valid strobe.
module sparkle_sequencer
  import sparkle_pkg::*;
#(
  parameter int FRAME_PIXELS = SPARKLE_FRAME_PIXELS,
  parameter int NUM_FRAMES   = SPARKLE_NUM_FRAMES,
  parameter int FRAME_TICKS  = 50_000_000,
  parameter int ADDR_W       = 12,
  parameter int CNT_W        = 32,
  parameter int ROM_LAT      = 1
) (
  input  logic         clk,
  input  logic         reset,
  sparkle_sequencer_if.slave bus
);

  localparam int FRAME_W = frame_w(NUM_FRAMES);
  localparam logic [CNT_W-1:0]   TICK_LAST  = CNT_W'(FRAME_TICKS - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(NUM_FRAMES - 1);
  localparam logic [ADDR_W-1:0]  PIX_STEP   = ADDR_W'(FRAME_PIXELS);
  localparam logic [ADDR_W:0]    PIX_LIMIT  = (ADDR_W+1)'(FRAME_PIXELS);

  if (FRAME_TICKS < 2) begin : g_bad_ticks
    $error("sparkle_sequencer: FRAME_TICKS must be >= 2");
  end
  if (64'(NUM_FRAMES) * 64'(FRAME_PIXELS) > (64'(1) << ADDR_W)) begin : g_bad_addr
    $error("sparkle_sequencer: sprite frames do not fit in ADDR_W");
  end
  if (ROM_LAT < 1 || ROM_LAT > 2) begin : g_bad_lat
    $error("sparkle_sequencer: ROM_LAT must be 1 or 2");
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   tick_q, tick_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               done_q, done_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  base;
  logic               busy;
  logic               v0;
  logic               valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      frame_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      frame_q <= frame_d;
      done_q  <= done_d;
    end
  end

  // A trigger always wins: it restarts at frame 0 even on a frame-step cycle
  // and suppresses the done pulse that step would otherwise produce.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.trigger || (bus.loop_mode && bus.sparkle_here)) begin
          state_d = PLAY;
          tick_d  = '0;
          frame_d = '0;
        end
      end
      PLAY: begin
        if (bus.trigger) begin
          tick_d  = '0;
          frame_d = '0;
        end else if (!bus.sparkle_here) begin
          state_d = PAUSE;
        end else if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (frame_q == FRAME_LAST) begin
            frame_d = '0;
            if (!bus.loop_mode) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            frame_d = frame_q + 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      PAUSE: begin
        if (bus.trigger) begin
          state_d = PLAY;
          tick_d  = '0;
          frame_d = '0;
        end else if (bus.sparkle_here) begin
          state_d = PLAY;
        end
      end
      default: begin
        state_d = IDLE;
        tick_d  = '0;
        frame_d = '0;
      end
    endcase
  end

  assign busy = (state_q != IDLE);
  assign base = ADDR_W'(frame_q) * PIX_STEP;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
    end else begin
      addr_q <= base + bus.sparkle_pixel;
    end
  end

  assign v0 = bus.sparkle_here & busy & ({1'b0, bus.sparkle_pixel} < PIX_LIMIT);

  sparkle_valid_pipe #(
    .DEPTH(ROM_LAT + 1)
  ) u_valid_pipe (
    .clk  (clk),
    .reset(reset),
    .d    (v0),
    .q    (valid)
  );

  assign bus.rom_addr      = addr_q;
  assign bus.sparkle_valid = valid;
  assign bus.sparkle       = bus.rom_q & valid;
  assign bus.frame_idx     = frame_q;
  assign bus.busy          = busy;
  assign bus.done          = done_q;
  assign bus.state         = state_q;

endmodule
